// File: rtl/rs_station_pkg.sv
// rs_station_pkg: constants shared by the reservation station and the
// load/store buffer. Holds the internal opcode encoding and the predicate
// that separates memory operations (which never enter this station).
package rs_station_pkg;

  localparam int OP_WIDTH = 6;

  typedef logic [OP_WIDTH-1:0] op_t;

  // Internal opcode encoding produced by decode.
  localparam op_t OP_NOP   = 6'd0;
  localparam op_t OP_LUI   = 6'd1;
  localparam op_t OP_AUIPC = 6'd2;
  localparam op_t OP_JAL   = 6'd3;
  localparam op_t OP_JALR  = 6'd4;
  localparam op_t OP_BEQ   = 6'd5;
  localparam op_t OP_BNE   = 6'd6;
  localparam op_t OP_LB    = 6'd10;
  localparam op_t OP_LH    = 6'd11;
  localparam op_t OP_LW    = 6'd12;
  localparam op_t OP_LBU   = 6'd13;
  localparam op_t OP_LHU   = 6'd14;
  localparam op_t OP_SB    = 6'd15;
  localparam op_t OP_SH    = 6'd16;
  localparam op_t OP_SW    = 6'd17;
  localparam op_t OP_ADDI  = 6'd20;
  localparam op_t OP_ADD   = 6'd30;
  localparam op_t OP_SUB   = 6'd31;
  localparam op_t OP_AND   = 6'd32;
  localparam op_t OP_OR    = 6'd33;

  // Loads and stores are handled by the load/store buffer.
  function automatic logic is_mem_op(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/rs_station_select.sv
// rs_station_select: two independent lowest-index priority encoders.
//   free_vec_i    : 1 = entry is free
//   ready_vec_i   : 1 = entry is ready to issue
//   free_idx_o / free_found_o   : lowest free entry and whether one exists
//   ready_idx_o / ready_found_o : lowest ready entry and whether one exists
// Purely combinational.
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     free_vec_i,
  input  logic [N-1:0]     ready_vec_i,
  output logic [IDX_W-1:0] free_idx_o,
  output logic             free_found_o,
  output logic [IDX_W-1:0] ready_idx_o,
  output logic             ready_found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    free_idx_o    = '0;
    free_found_o  = 1'b0;
    ready_idx_o   = '0;
    ready_found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec_i[i]) begin
        free_idx_o   = IDX_W'(i);
        free_found_o = 1'b1;
      end
      if (ready_vec_i[i]) begin
        ready_idx_o   = IDX_W'(i);
        ready_found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// rs_station: reservation station for the ALU/branch path.
// Holds up to RS_SIZE non-memory instructions, snoops the ALU and LSB
// result buses for missing operands, and issues one ready instruction per
// cycle (lowest index first) into registered outputs.
//
// Handshake: dispatch (iDP_en) is valid-only; there is no ready back to
// dispatch. Upstream must stop dispatching once oRS_full is high; oRS_full
// asserts with one free slot left to absorb an instruction already in
// flight. Issue (oRS_en) is valid-only; the ALU accepts every issue.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable; low = frozen)
//   iDP_*   : dispatched instruction (op, pc, imm, rd/rs tags, rs data)
//   iALU_*  : ALU result broadcast (en, nick, data)
//   iLSB_*  : load/store buffer result broadcast (en, nick, data)
//   iROB_clr: flush on mispredict, highest priority
//   oRS_full: stall request to fetch/dispatch (registered)
//   oRS_*   : issued instruction, all registered, oRS_en is a 1-cycle pulse
module rs_station
  import rs_station_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int NICK_W  = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iDP_en,
  input  logic [OP_W-1:0]   iDP_op,
  input  logic [DATA_W-1:0] iDP_pc,
  input  logic [DATA_W-1:0] iDP_imm,
  input  logic [NICK_W-1:0] iDP_rd_nick,
  input  logic [NICK_W-1:0] iDP_rs1_nick,
  input  logic [NICK_W-1:0] iDP_rs2_nick,
  input  logic [DATA_W-1:0] iDP_rs1_dt,
  input  logic [DATA_W-1:0] iDP_rs2_dt,
  input  logic              iALU_en,
  input  logic [NICK_W-1:0] iALU_nick,
  input  logic [DATA_W-1:0] iALU_dt,
  input  logic              iLSB_en,
  input  logic [NICK_W-1:0] iLSB_nick,
  input  logic [DATA_W-1:0] iLSB_dt,
  input  logic              iROB_clr,
  output logic              oRS_full,
  output logic              oRS_en,
  output logic [OP_W-1:0]   oRS_op,
  output logic [DATA_W-1:0] oRS_pc,
  output logic [DATA_W-1:0] oRS_imm,
  output logic [NICK_W-1:0] oRS_rd_nick,
  output logic [DATA_W-1:0] oRS_rs1_dt,
  output logic [DATA_W-1:0] oRS_rs2_dt
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  // Entry state
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q  [RS_SIZE];
  logic [OP_W-1:0]    op_d  [RS_SIZE];
  logic [DATA_W-1:0]  pc_q  [RS_SIZE];
  logic [DATA_W-1:0]  pc_d  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [DATA_W-1:0]  imm_d [RS_SIZE];
  logic [NICK_W-1:0]  rd_q  [RS_SIZE];
  logic [NICK_W-1:0]  rd_d  [RS_SIZE];
  logic [NICK_W-1:0]  q1_q  [RS_SIZE];
  logic [NICK_W-1:0]  q1_d  [RS_SIZE];
  logic [NICK_W-1:0]  q2_q  [RS_SIZE];
  logic [NICK_W-1:0]  q2_d  [RS_SIZE];
  logic [DATA_W-1:0]  v1_q  [RS_SIZE];
  logic [DATA_W-1:0]  v1_d  [RS_SIZE];
  logic [DATA_W-1:0]  v2_q  [RS_SIZE];
  logic [DATA_W-1:0]  v2_d  [RS_SIZE];

  // Output registers
  logic              iss_en_q, iss_en_d;
  logic [OP_W-1:0]   iss_op_q, iss_op_d;
  logic [DATA_W-1:0] iss_pc_q, iss_pc_d;
  logic [DATA_W-1:0] iss_imm_q, iss_imm_d;
  logic [NICK_W-1:0] iss_rd_q, iss_rd_d;
  logic [DATA_W-1:0] iss_rs1_q, iss_rs1_d;
  logic [DATA_W-1:0] iss_rs2_q, iss_rs2_d;
  logic              full_q, full_d;

  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               free_found, sel_found;
  logic               dp_accept;
  logic [CNT_W-1:0]   busy_cnt;

  // Returns {tag, data} with the tag cleared and data replaced if an
  // enabled broadcast matches a nonzero tag. ALU wins a double hit.
  function automatic logic [NICK_W+DATA_W-1:0] snoop(input logic [NICK_W-1:0] tag,
                                                     input logic [DATA_W-1:0] dt);
    logic [NICK_W+DATA_W-1:0] r;
    r = {tag, dt};
    if (tag != '0) begin
      if (iALU_en && iALU_nick == tag) r = {{NICK_W{1'b0}}, iALU_dt};
      else if (iLSB_en && iLSB_nick == tag) r = {{NICK_W{1'b0}}, iLSB_dt};
    end
    return r;
  endfunction

  // Readiness uses registered tags only: a wakeup this cycle issues next cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
  end

  rs_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .free_vec_i    (~busy_q),
    .ready_vec_i   (ready_vec),
    .free_idx_o    (free_idx),
    .free_found_o  (free_found),
    .ready_idx_o   (sel_idx),
    .ready_found_o (sel_found)
  );

  assign dp_accept = iDP_en && !iROB_clr && !is_mem_op(iDP_op);

  always_comb begin
    busy_d    = busy_q;
    op_d      = op_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    iss_en_d  = 1'b0;  // also covers rdy low: no repeated issue while frozen
    iss_op_d  = iss_op_q;
    iss_pc_d  = iss_pc_q;
    iss_imm_d = iss_imm_q;
    iss_rd_d  = iss_rd_q;
    iss_rs1_d = iss_rs1_q;
    iss_rs2_d = iss_rs2_q;
    full_d    = full_q;
    busy_cnt  = '0;
    if (rdy) begin
      if (iROB_clr) begin
        busy_d = '0;
        full_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            {q1_d[i], v1_d[i]} = snoop(q1_q[i], v1_q[i]);
            {q2_d[i], v2_d[i]} = snoop(q2_q[i], v2_q[i]);
          end
        end
        if (sel_found) begin
          iss_en_d        = 1'b1;
          iss_op_d        = op_q[sel_idx];
          iss_pc_d        = pc_q[sel_idx];
          iss_imm_d       = imm_q[sel_idx];
          iss_rd_d        = rd_q[sel_idx];
          iss_rs1_d       = v1_q[sel_idx];
          iss_rs2_d       = v2_q[sel_idx];
          busy_d[sel_idx] = 1'b0;
        end
        // free_idx comes from busy_q, so it never aliases the issuing slot.
        // With no free entry the dispatch is dropped.
        if (dp_accept && free_found) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = iDP_op;
          pc_d[free_idx]   = iDP_pc;
          imm_d[free_idx]  = iDP_imm;
          rd_d[free_idx]   = iDP_rd_nick;
          {q1_d[free_idx], v1_d[free_idx]} = snoop(iDP_rs1_nick, iDP_rs1_dt);
          {q2_d[free_idx], v2_d[free_idx]} = snoop(iDP_rs2_nick, iDP_rs2_dt);
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          busy_cnt = busy_cnt + CNT_W'(busy_d[i]);
        end
        // Full when at most one entry will be free after this edge.
        full_d = (busy_cnt >= CNT_W'(RS_SIZE - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      iss_en_q  <= 1'b0;
      iss_op_q  <= '0;
      iss_pc_q  <= '0;
      iss_imm_q <= '0;
      iss_rd_q  <= '0;
      iss_rs1_q <= '0;
      iss_rs2_q <= '0;
      full_q    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      iss_en_q  <= iss_en_d;
      iss_op_q  <= iss_op_d;
      iss_pc_q  <= iss_pc_d;
      iss_imm_q <= iss_imm_d;
      iss_rd_q  <= iss_rd_d;
      iss_rs1_q <= iss_rs1_d;
      iss_rs2_q <= iss_rs2_d;
      full_q    <= full_d;
    end
  end

  // Payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    pc_q  <= pc_d;
    imm_q <= imm_d;
    rd_q  <= rd_d;
    q1_q  <= q1_d;
    q2_q  <= q2_d;
    v1_q  <= v1_d;
    v2_q  <= v2_d;
  end

  assign oRS_full    = full_q;
  assign oRS_en      = iss_en_q;
  assign oRS_op      = iss_op_q;
  assign oRS_pc      = iss_pc_q;
  assign oRS_imm     = iss_imm_q;
  assign oRS_rd_nick = iss_rd_q;
  assign oRS_rs1_dt  = iss_rs1_q;
  assign oRS_rs2_dt  = iss_rs2_q;

endmodule
